// File: rtl/write_back_stage.sv
// ---------------------------------------------------------------------------
// write_back_stage
//
// Final pipeline stage and architectural register file. Selects the value to
// retire (load data or ALU result), commits it to a 32 x 32-bit register file,
// exposes two combinational read ports for decode, a registered forwarding
// tap for execute-stage hazard logic, and a retired-write counter for debug.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   -> read ports forward the in-flight write value when the read
//                address matches a nonzero, enabled destination.
//   undefined -> read ports return stored contents only.
//
// Ports:
//   clk                 pipeline clock, rising-edge state updates
//   resetN              asynchronous active-low reset
//   writeBackControlIn  [1] regWrite, [0] memToReg
//   readData            load data from memory stage
//   resultIn            ALU result from memory stage
//   rdIn                destination register
//   hold                stall, freezes all state
//   rsAddr / rtAddr     decode read port addresses
//   rsData / rtData     decode read port data (combinational)
//   wbRegWrite          registered: last committed cycle wrote a register
//   wbRd                registered: destination of last commit
//   wbData              registered: value of last commit
//   retireCount         register writes committed since reset
// ---------------------------------------------------------------------------
module write_back_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_COUNT   = 32,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic [1:0]             writeBackControlIn,
    input  logic [DATA_WIDTH-1:0]  readData,
    input  logic [DATA_WIDTH-1:0]  resultIn,
    input  logic [4:0]             rdIn,
    input  logic                   hold,
    input  logic [4:0]             rsAddr,
    input  logic [4:0]             rtAddr,
    output logic [DATA_WIDTH-1:0]  rsData,
    output logic [DATA_WIDTH-1:0]  rtData,
    output logic                   wbRegWrite,
    output logic [4:0]             wbRd,
    output logic [DATA_WIDTH-1:0]  wbData,
    output logic [COUNT_WIDTH-1:0] retireCount
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    logic                  reg_write;
    logic                  mem_to_reg;
    logic [DATA_WIDTH-1:0] write_value;
    logic                  write_en;

    assign reg_write  = writeBackControlIn[1];
    assign mem_to_reg = writeBackControlIn[0];

    // A known select keeps an undefined readData out of the ALU path.
    assign write_value = mem_to_reg ? readData : resultIn;

    // Writes to r0 are dropped entirely, so they are also not counted.
    assign write_en = reg_write && !hold && (rdIn != 5'd0);

    // Read port lookup: r0 is hardwired to zero; optional same-cycle bypass.
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [4:0] addr);
        logic [DATA_WIDTH-1:0] value;
        if (addr == 5'd0) begin
            value = '0;
        end else begin
            value = regs[addr];
`ifdef WB_BYPASS_EN
            if (write_en && (addr == rdIn)) begin
                value = write_value;
            end
`endif
        end
        return value;
    endfunction

    assign rsData = read_port(rsAddr);
    assign rtData = read_port(rtAddr);

    // Commit stage: register file, forwarding tap and retire counter.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
            wbRegWrite  <= 1'b0;
            wbRd        <= '0;
            wbData      <= '0;
            retireCount <= '0;
        end else if (write_en) begin
            regs[rdIn]  <= write_value;
            wbRegWrite  <= 1'b1;
            wbRd        <= rdIn;
            wbData      <= write_value;
            retireCount <= retireCount + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end else if (!hold) begin
            // Non-writing, non-held cycle: tap goes invalid, payload retained.
            wbRegWrite  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_write_back_stage.sv
// ---------------------------------------------------------------------------
// tb_write_back_stage
//
// Directed-vector bench for write_back_stage. Inputs change one time unit
// after the rising edge; outputs are sampled one time unit after an edge or
// mid-cycle for combinational / asynchronous-reset checks.
// ---------------------------------------------------------------------------
module tb_write_back_stage;

    logic        clk;
    logic        resetN;
    logic [1:0]  writeBackControlIn;
    logic [31:0] readData;
    logic [31:0] resultIn;
    logic [4:0]  rdIn;
    logic        hold;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic        wbRegWrite;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic [31:0] retireCount;

    int checks   = 0;
    int failures = 0;

    write_back_stage #(
        .DATA_WIDTH (32),
        .REG_COUNT  (32),
        .COUNT_WIDTH(32)
    ) dut (
        .clk               (clk),
        .resetN            (resetN),
        .writeBackControlIn(writeBackControlIn),
        .readData          (readData),
        .resultIn          (resultIn),
        .rdIn              (rdIn),
        .hold              (hold),
        .rsAddr            (rsAddr),
        .rtAddr            (rtAddr),
        .rsData            (rsData),
        .rtData            (rtData),
        .wbRegWrite        (wbRegWrite),
        .wbRd              (wbRd),
        .wbData            (wbData),
        .retireCount       (retireCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ctl, input logic [31:0] rd_data,
                         input logic [31:0] res, input logic [4:0] rd);
        writeBackControlIn = ctl;
        readData           = rd_data;
        resultIn           = res;
        rdIn               = rd;
    endtask

    initial begin
        resetN = 1'b0;
        hold   = 1'b0;
        rsAddr = 5'd0;
        rtAddr = 5'd0;
        drive(2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        tick();

        // Reset state
        check("rst_wbRegWrite", {63'b0, wbRegWrite}, 64'd0);
        check("rst_retireCount", {32'b0, retireCount}, 64'd0);
        check("rst_wbData", {32'b0, wbData}, 64'd0);
        resetN = 1'b1;

        // ALU write to r7
        drive(2'b10, 32'h0, 32'h0000_1234, 5'd7);
        tick();
        rsAddr = 5'd7;
        #1;
        check("r7_read", {32'b0, rsData}, 64'h1234);
        check("r7_wbRegWrite", {63'b0, wbRegWrite}, 64'd1);
        check("r7_wbRd", {59'b0, wbRd}, 64'd7);
        check("r7_wbData", {32'b0, wbData}, 64'h1234);
        check("r7_count", {32'b0, retireCount}, 64'd1);

        // Load write to r3, then ALU write with undefined readData
        drive(2'b11, 32'hDEAD_BEEF, 32'd20, 5'd3);
        tick();
        rsAddr = 5'd3;
        #1;
        check("r3_load", {32'b0, rsData}, 64'hDEAD_BEEF);
        check("r3_load_count", {32'b0, retireCount}, 64'd2);
        drive(2'b10, 32'hxxxx_xxxx, 32'd20, 5'd3);
        tick();
        check("r3_alu", {32'b0, rsData}, 64'd20);
        check("r3_alu_wbData", {32'b0, wbData}, 64'd20);
        check("r3_alu_count", {32'b0, retireCount}, 64'd3);

        // Write to r0 is dropped
        drive(2'b10, 32'h0, 32'hFFFF_FFFF, 5'd0);
        tick();
        rsAddr = 5'd0;
        #1;
        check("r0_read", {32'b0, rsData}, 64'd0);
        check("r0_wbRegWrite", {63'b0, wbRegWrite}, 64'd0);
        check("r0_wbRd_kept", {59'b0, wbRd}, 64'd3);
        check("r0_wbData_kept", {32'b0, wbData}, 64'd20);
        check("r0_count", {32'b0, retireCount}, 64'd3);

        // Hold freezes state for three edges
        drive(2'b10, 32'h0, 32'd99, 5'd4);
        hold   = 1'b1;
        rtAddr = 5'd4;
        tick();
        tick();
        tick();
        check("hold_r4", {32'b0, rtData}, 64'd0);
        check("hold_wbRd", {59'b0, wbRd}, 64'd3);
        check("hold_count", {32'b0, retireCount}, 64'd3);
        hold = 1'b0;
        tick();
        check("release_r4", {32'b0, rtData}, 64'd99);
        check("release_wbRd", {59'b0, wbRd}, 64'd4);
        check("release_count", {32'b0, retireCount}, 64'd4);

        // Hold while the tap is valid keeps wbRegWrite high
        drive(2'b00, 32'h0, 32'h0, 5'd0);
        hold = 1'b1;
        tick();
        check("hold_tap_valid", {63'b0, wbRegWrite}, 64'd1);
        hold = 1'b0;
        tick();
        check("idle_tap_invalid", {63'b0, wbRegWrite}, 64'd0);
        check("idle_wbData_kept", {32'b0, wbData}, 64'd99);

        // Same-cycle read of the register being written
        drive(2'b10, 32'h0, 32'h0000_1111, 5'd12);
        tick();
        drive(2'b10, 32'h0, 32'h0000_A5A5, 5'd12);
        rsAddr = 5'd12;
        rtAddr = 5'd12;
        #1;
`ifdef WB_BYPASS_EN
        check("bypass_rs_pre", {32'b0, rsData}, 64'hA5A5);
        check("bypass_rt_pre", {32'b0, rtData}, 64'hA5A5);
`else
        check("nobypass_rs_pre", {32'b0, rsData}, 64'h1111);
        check("nobypass_rt_pre", {32'b0, rtData}, 64'h1111);
`endif
        tick();
        check("r12_rs_post", {32'b0, rsData}, 64'hA5A5);
        check("r12_rt_post", {32'b0, rtData}, 64'hA5A5);
        check("r12_count", {32'b0, retireCount}, 64'd6);

        // Writes to r5 and r9, then asynchronous reset mid-cycle
        drive(2'b10, 32'h0, 32'h0000_0055, 5'd5);
        tick();
        drive(2'b11, 32'h0000_0099, 32'h0, 5'd9);
        tick();
        rsAddr = 5'd5;
        rtAddr = 5'd9;
        #1;
        check("r5_before_rst", {32'b0, rsData}, 64'h55);
        check("r9_before_rst", {32'b0, rtData}, 64'h99);
        check("count_before_rst", {32'b0, retireCount}, 64'd8);
        drive(2'b10, 32'h0, 32'h0000_7777, 5'd5);
        resetN = 1'b0;
        #1;
        check("rst_async_r5", {32'b0, rsData}, 64'd0);
        check("rst_async_r9", {32'b0, rtData}, 64'd0);
        check("rst_async_count", {32'b0, retireCount}, 64'd0);
        check("rst_async_wbRegWrite", {63'b0, wbRegWrite}, 64'd0);
        check("rst_async_wbRd", {59'b0, wbRd}, 64'd0);
        tick();
        check("rst_edge_no_commit", {32'b0, rsData}, 64'd0);
        check("rst_edge_count", {32'b0, retireCount}, 64'd0);
        resetN = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        check("post_rst_r5", {32'b0, rsData}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
